// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: command codes, NZCV bit positions,
// the issue-stage operation record and the legal-command check.
package alu_arbiter_pkg;

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } alu_cmd_e;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   localparam int DATA_W = 32;
   localparam int CMD_W  = 4;
   localparam int STAT_W = 4;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              s;
   } op_t;

   function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd);
      case (cmd)
         CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
         CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: cmd_legal = 1'b1;
         default:                            cmd_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr wins; returns one-hot
// grant, winner index and the pointer value that follows the winner.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic [ID_W-1:0]    next_ptr,
   output logic               any
);

   int cand;

   always_comb begin
      grant    = '0;
      idx      = '0;
      next_ptr = ptr;
      any      = 1'b0;
      cand     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = ID_W'(cand);
            next_ptr    = (cand == NUM_REQ - 1) ? '0 : ID_W'(cand + 1);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// issue/capture pipeline (latency 2) and ownership of the NZCV register.
// Optional ALU_ARB_LOCK_EN adds req_lock for exclusive multi-op sequences.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
   input  logic [DATA_W*NUM_REQ-1:0] req_a,
   input  logic [DATA_W*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_s,
`ifdef ALU_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [DATA_W-1:0]         alu_in1,
   output logic [DATA_W-1:0]         alu_in2,
   output logic [STAT_W-1:0]         alu_sr,
   output logic [CMD_W-1:0]          alu_cmd,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic [STAT_W-1:0]         alu_status,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic [STAT_W-1:0]         rsp_status,
   output logic                      rsp_err,
   output logic [STAT_W-1:0]         nzcv
);

   logic [NUM_REQ-1:0] req_eff;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    next_ptr;
   logic               grant_any;
   logic [ID_W-1:0]    rr_ptr;
   logic               advance;
   logic               take;
   op_t                sel_op;

   op_t                issue_op;
   logic [ID_W-1:0]    issue_id;
   logic               issue_valid;
   logic               issue_legal;

`ifdef ALU_ARB_LOCK_EN
   logic               lock_active;
   logic [ID_W-1:0]    lock_id;

   // While locked only the owner can be picked, so the pointer scan is moot.
   always_comb begin
      req_eff = req_valid;
      if (lock_active) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (ID_W'(i) != lock_id)
               req_eff[i] = 1'b0;
      end
   end
`else
   always_comb req_eff = req_valid;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req      (req_eff),
      .ptr      (rr_ptr),
      .grant    (grant),
      .idx      (grant_idx),
      .next_ptr (next_ptr),
      .any      (grant_any)
   );

   // The issue stage always drains into the response stage when advancing,
   // so a new grant is possible whenever the pipeline advances.
   assign advance   = !rsp_valid || rsp_ready;
   assign take      = advance && grant_any;
   assign req_ready = advance ? grant : '0;

   always_comb begin
      sel_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_op.cmd = req_cmd[CMD_W*i +: CMD_W];
            sel_op.a   = req_a[DATA_W*i +: DATA_W];
            sel_op.b   = req_b[DATA_W*i +: DATA_W];
            sel_op.s   = req_s[i];
         end
      end
   end

   assign issue_legal = cmd_legal(issue_op.cmd);
   assign alu_in1     = issue_op.a;
   assign alu_in2     = issue_op.b;
   assign alu_cmd     = issue_op.cmd;
   assign alu_sr      = nzcv;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid <= 1'b0;
         issue_op    <= '0;
         issue_id    <= '0;
         rr_ptr      <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_result  <= '0;
         rsp_status  <= '0;
         rsp_err     <= 1'b0;
         nzcv        <= '0;
      end else if (advance) begin
         issue_valid <= take;
         if (take) begin
            issue_op <= sel_op;
            issue_id <= grant_idx;
            rr_ptr   <= next_ptr;
         end
         rsp_valid <= issue_valid;
         if (issue_valid) begin
            rsp_id     <= issue_id;
            rsp_result <= alu_out;
            rsp_status <= alu_status;
            rsp_err    <= !issue_legal;
            if (issue_op.s && issue_legal)
               nzcv <= alu_status;
         end
      end
   end

`ifdef ALU_ARB_LOCK_EN
   // Lock state follows the req_lock of every accepted transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_active <= 1'b0;
         lock_id     <= '0;
      end else if (take) begin
         lock_active <= req_lock[grant_idx];
         lock_id     <= grant_idx;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the ALU port,
// a negedge monitor models arbitration/pipeline occupancy and checks responses.
module tb_alu_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [7:0]  id;
   } sb_op_t;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [4*NUM_REQ-1:0]  req_cmd;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    req_s;
`ifdef ALU_ARB_LOCK_EN
   logic [NUM_REQ-1:0]    req_lock;
`endif
   logic [31:0]           alu_in1;
   logic [31:0]           alu_in2;
   logic [3:0]            alu_sr;
   logic [3:0]            alu_cmd;
   logic [31:0]           alu_out;
   logic [3:0]            alu_status;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_result;
   logic [3:0]            rsp_status;
   logic                  rsp_err;
   logic [3:0]            nzcv;

   int total = 0;
   int bad   = 0;

   sb_op_t sb[$];
   int     m_ptr;
   bit     m_issue_full;
   bit     m_rsp_full;
   logic [3:0] m_nzcv;
   bit     m_lock;
   int     m_lock_id;

   alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_s      (req_s),
`ifdef ALU_ARB_LOCK_EN
      .req_lock   (req_lock),
`endif
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_sr     (alu_sr),
      .alu_cmd    (alu_cmd),
      .alu_out    (alu_out),
      .alu_status (alu_status),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_status (rsp_status),
      .rsp_err    (rsp_err),
      .nzcv       (nzcv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ARM-style ALU: {N,Z,C,V, result}; illegal codes yield a marker pattern.
   function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] sr);
      logic [32:0] w;
      logic [31:0] r;
      logic c, v;
      c = sr[1];
      v = sr[0];
      w = '0;
      r = '0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd2, 4'd3: begin
            w = {1'b0, a} + {1'b0, b} + ((cmd == 4'd3) ? {32'd0, sr[1]} : 33'd0);
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd4, 4'd5: begin
            w = {1'b0, a} + {1'b0, ~b} + ((cmd == 4'd4) ? 33'd1 : {32'd0, sr[1]});
            r = w[31:0];
            c = w[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         default: return {4'b1111, a ^ 32'hDEADBEEF};
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic bit legal(input logic [3:0] cmd);
      return (cmd >= 4'd1) && (cmd <= 4'd9);
   endfunction

   always_comb {alu_status, alu_out} = alu_ref(alu_cmd, alu_in1, alu_in2, alu_sr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: arbitration/occupancy model plus response scoreboard.
   always @(negedge clk) begin
      int win;
      int j;
      bit adv;
      logic [NUM_REQ-1:0] exp_ready;
      sb_op_t op;
      sb_op_t nw;
      logic [35:0] r;
      if (rst) begin
         sb.delete();
         m_ptr = 0; m_issue_full = 0; m_rsp_full = 0;
         m_nzcv = '0; m_lock = 0; m_lock_id = 0;
      end else begin
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp_full});
         adv = !m_rsp_full || rsp_ready;
         win = -1;
         exp_ready = '0;
         if (adv) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               j = (m_ptr + k) % NUM_REQ;
               if (win < 0 && req_valid[j] && (!m_lock || j == m_lock_id))
                  win = j;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
         if (m_rsp_full && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd0, 32'd1);
            end else begin
               op = sb.pop_front();
               r = alu_ref(op.cmd, op.a, op.b, m_nzcv);
               if (legal(op.cmd) && op.s) m_nzcv = r[35:32];
               chk("rsp_id", {31'd0, rsp_id}, {24'd0, op.id});
               chk("rsp_result", rsp_result, r[31:0]);
               chk("rsp_status", {28'd0, rsp_status}, {28'd0, r[35:32]});
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, !legal(op.cmd)});
               chk("nzcv", {28'd0, nzcv}, {28'd0, m_nzcv});
            end
         end
         if (adv) begin
            m_rsp_full   = m_issue_full;
            m_issue_full = (win >= 0);
            if (win >= 0) begin
               nw.cmd = req_cmd[4*win +: 4];
               nw.a   = req_a[32*win +: 32];
               nw.b   = req_b[32*win +: 32];
               nw.s   = req_s[win];
               nw.id  = 8'(win);
               sb.push_back(nw);
               m_ptr = (win + 1) % NUM_REQ;
`ifdef ALU_ARB_LOCK_EN
               m_lock    = req_lock[win];
               m_lock_id = win;
`endif
            end
         end
      end
   end

   task automatic set_req(input int id, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
      req_valid[id]       = 1'b1;
      req_cmd[4*id +: 4]  = cmd;
      req_a[32*id +: 32]  = a;
      req_b[32*id +: 32]  = b;
      req_s[id]           = s;
   endtask

   task automatic issue(input int id, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
      @(posedge clk); #1;
      req_valid = '0;
      set_req(id, cmd, a, b, s);
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 20);
      if (!rsp_valid) begin
         total++;
         bad++;
         $display("FAIL %s timeout waiting for rsp_valid actual=0 required=1", name);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   logic [3:0] legal_cmds [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

   function automatic logic [3:0] rand_cmd();
      if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
      return legal_cmds[$urandom_range(0, 8)];
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_cmd = '0; req_a = '0; req_b = '0; req_s = '0;
`ifdef ALU_ARB_LOCK_EN
      req_lock = '0;
`endif
      rsp_ready = 1'b1;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_nzcv", {28'd0, nzcv}, 32'd0);
      chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
      chk("reset_rsp_result", rsp_result, 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);

      // Single ADD 5+7 with status update.
      issue(0, 4'd2, 32'd5, 32'd7, 1'b1);
      wait_rsp("add_wait");
      chk("add_id", {31'd0, rsp_id}, 32'd0);
      chk("add_result", rsp_result, 32'd12);
      chk("add_nzcv", {28'd0, nzcv}, 32'd0);
      idle(2);

      // Both requesters continuously valid: grants must alternate.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         set_req(0, rand_cmd(), $urandom, $urandom, 1'(i % 2));
         set_req(1, rand_cmd(), $urandom, $urandom, 1'b0);
      end
      @(posedge clk); #1;
      req_valid = '0;
      idle(4);

      // SUB 5-5 sets Z and C; ADC 1+1 consumes C without updating flags.
      issue(0, 4'd4, 32'd5, 32'd5, 1'b1);
      wait_rsp("sub_wait");
      chk("sub_nzcv", {28'd0, nzcv}, 32'h6);
      issue(0, 4'd3, 32'd1, 32'd1, 1'b0);
      wait_rsp("adc_wait");
      chk("adc_result", rsp_result, 32'd3);
      chk("adc_nzcv", {28'd0, nzcv}, 32'h6);
      idle(2);

      // Response stall with requests pending.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         set_req(0, rand_cmd(), $urandom, $urandom, 1'b1);
         set_req(1, rand_cmd(), $urandom, $urandom, 1'b1);
         rsp_ready = !(i >= 2 && i < 5);
         if (i >= 3 && i < 5) begin
            @(negedge clk);
            chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
         end
      end
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      idle(4);

      // Illegal command with s=1: error flagged, flags untouched.
      issue(1, 4'd2, 32'h7FFFFFFF, 32'd1, 1'b1);
      wait_rsp("pre_illegal_wait");
      issue(1, 4'd15, 32'h1234, 32'h5678, 1'b1);
      wait_rsp("illegal_wait");
      chk("illegal_err", {31'd0, rsp_err}, 32'd1);
      chk("illegal_nzcv", {28'd0, nzcv}, 32'h9);
      idle(2);

      // Reset with two operations in flight.
      @(posedge clk); #1;
      set_req(0, 4'd4, 32'd1, 32'd2, 1'b1);
      set_req(1, 4'd2, 32'd3, 32'd4, 1'b1);
      idle(2);
      req_valid = '0;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_flush_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_flush_nzcv", {28'd0, nzcv}, 32'd0);
      end

`ifdef ALU_ARB_LOCK_EN
      // 64-bit add chain under lock: req1 must not be granted in between.
      @(posedge clk); #1;
      req_valid = '0;
      set_req(0, 4'd2, 32'hFFFFFFFF, 32'd1, 1'b1);
      req_lock = 2'b01;
      @(negedge clk);
      chk("lock_first_ready", {30'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      set_req(0, 4'd3, 32'd0, 32'd0, 1'b1);
      set_req(1, 4'd6, 32'hF0F0, 32'hFF00, 1'b0);
      req_lock = 2'b00;
      @(negedge clk);
      chk("lock_hold_ready", {30'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("lock_release_ready", {30'd0, req_ready}, 32'd2);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("lock_adc_valid", {31'd0, rsp_valid}, 32'd1);
      chk("lock_adc_id", {31'd0, rsp_id}, 32'd0);
      chk("lock_adc_result", rsp_result, 32'd1);
      idle(4);
`endif

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         req_valid = NUM_REQ'($urandom);
         for (int r = 0; r < NUM_REQ; r++)
            set_req(r, rand_cmd(), $urandom, $urandom, 1'($urandom));
         req_valid = NUM_REQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARB_LOCK_EN
         req_lock = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom) : '0;
`endif
      end
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
`ifdef ALU_ARB_LOCK_EN
      req_lock = '0;
`endif
      idle(8);
      @(negedge clk);
      chk("drain_sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
